// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b - borrow_in, LSB first,
// one full-subtractor cell and a borrow flop, valid/ready on both sides.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_n;
  logic [CNT_W-1:0] idx;
  logic             br;

  logic ai;
  logic bi;
  logic d;
  logic br_n;
  logic last;
  logic take;
  logic give;

  // Current bit pair sits at the bottom of the operand shifters.
  assign ai = a_r[0];
  assign bi = b_r[0];

  // Full-subtractor cell.
  assign d    = ai ^ bi ^ br;
  assign br_n = (~ai & bi) | (~(ai ^ bi) & br);

  // New bit enters at the MSB; after WIDTH steps bit 0 is the LSB.
  assign acc_n = WIDTH'({d, acc} >> 1);

  assign last = (idx == LAST);
  assign take = (state == IDLE) && in_valid;
  assign give = (state == DONE) && out_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (take) nxt = RUN;
      end
      RUN: begin
        if (last) nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (give) nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // Operand capture and the serial bit loop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      br  <= 1'b0;
      idx <= '0;
    end else if (take) begin
      a_r <= a;
      b_r <= b;
      acc <= '0;
      br  <= borrow_in;
      idx <= '0;
    end else if (state == RUN) begin
      a_r <= a_r >> 1;
      b_r <= b_r >> 1;
      acc <= acc_n;
      br  <= br_n;
      idx <= idx + CNT_W'(1);
    end
  end

  // Result registers, loaded only on the final bit step.
  // At that step ai/bi are the operand MSBs and d is the result MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else if ((state == RUN) && last) begin
      diff       <= acc_n;
      borrow_out <= br_n;
      ovf        <= (ai != bi) && (d != ai);
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: directed literal cases plus random
// back-to-back traffic on WIDTH=8 and WIDTH=1 against an arithmetic model.
module tb_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic       iv8, ir8, bi8, ov8, or8, bo8, ovf8, busy8;
  logic [7:0] a8, b8, d8;

  logic       iv1, ir1, bi1, ov1, or1, bo1, ovf1, busy1;
  logic [0:0] a1, b1, d1;

  int errors = 0;
  int checks = 0;

  logic [65:0] q8[$];
  logic [65:0] q1[$];
  bit done = 1'b0;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .borrow_in(bi8),
    .out_valid(ov8), .out_ready(or8),
    .diff(d8), .borrow_out(bo8), .ovf(ovf8),
    .busy(busy8)
  );

  serial_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .borrow_in(bi1),
    .out_valid(ov1), .out_ready(or1),
    .diff(d1), .borrow_out(bo1), .ovf(ovf1),
    .busy(busy1)
  );

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // {ovf, borrow, diff}: unsigned a - b - bin mod 2^w.
  function automatic logic [65:0] model(input logic [63:0] a,
                                        input logic [63:0] b,
                                        input logic bin,
                                        input int w);
    logic [63:0] m;
    logic [64:0] r;
    logic [63:0] dd;
    logic        brw;
    logic        o;
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r   = {1'b0, a & m} - {1'b0, b & m} - 65'(bin);
    dd  = r[63:0] & m;
    brw = ({1'b0, a & m} < ({1'b0, b & m} + 65'(bin)));
    o   = (a[w-1] != b[w-1]) && (dd[w-1] != a[w-1]);
    return {o, brw, dd};
  endfunction

  // Single compare process: record accepts, check results while valid.
  always @(negedge clk) begin
    logic [65:0] e;
    if (!reset_n) begin
      q8.delete();
      q1.delete();
    end else begin
      if (iv8 && ir8) q8.push_back(model(64'(a8), 64'(b8), bi8, 8));
      if (iv1 && ir1) q1.push_back(model(64'(a1), 64'(b1), bi1, 1));
      chk("rdy8", 64'(ir8), 64'(!busy8));
      chk("rdy1", 64'(ir1), 64'(!busy1));
      if (ov8) begin
        if (q8.size() == 0) begin
          chk("orphan8", 64'(1), 64'(0));
        end else begin
          e = q8[0];
          chk("diff8", 64'(d8), 64'(e[7:0]));
          chk("brw8", 64'(bo8), 64'(e[64]));
          chk("ovf8", 64'(ovf8), 64'(e[65]));
          chk("inr8_done", 64'(ir8), 64'(0));
          if (or8) void'(q8.pop_front());
        end
      end
      if (ov1) begin
        if (q1.size() == 0) begin
          chk("orphan1", 64'(1), 64'(0));
        end else begin
          e = q1[0];
          chk("diff1", 64'(d1), 64'(e[0]));
          chk("brw1", 64'(bo1), 64'(e[64]));
          chk("ovf1", 64'(ovf1), 64'(e[65]));
          if (or1) void'(q1.pop_front());
        end
      end
    end
  end

  // One WIDTH=8 op with literal expectations; optional hold in DONE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic bin, input logic [7:0] ed,
                     input logic eb, input logic eo, input int hold);
    int lat;
    lat = -1;
    iv8 = 1'b1; a8 = a; b8 = b; bi8 = bin;
    @(posedge clk); #1;
    iv8 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ov8) begin
        lat = i;
        break;
      end
    end
    chk("lat8", 64'(lat), 64'(8));
    chk("lit_diff", 64'(d8), 64'(ed));
    chk("lit_brw", 64'(bo8), 64'(eb));
    chk("lit_ovf", 64'(ovf8), 64'(eo));
    for (int i = 0; i < hold; i++) begin
      iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", 64'(ov8), 64'(1));
      chk("hold_inr", 64'(ir8), 64'(0));
      chk("hold_diff", 64'(d8), 64'(ed));
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("post_valid", 64'(ov8), 64'(0));
    chk("post_inr", 64'(ir8), 64'(1));
    chk("post_q", 64'(q8.size()), 64'(0));
    chk("post_keep", 64'(d8), 64'(ed));
  endtask

  task automatic drv8(input int n);
    int  tries;
    logic took;
    for (int k = 0; k < n; k++) begin
      tries = 0; took = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      bi8 = 1'($urandom); iv8 = 1'b1;
      while (!took && tries < 400) begin
        @(negedge clk); took = ir8;
        @(posedge clk); #1;
        tries++;
      end
      if (!took) begin
        chk("acc8_timeout", 64'(0), 64'(1));
        iv8 = 1'b0;
        return;
      end
      if ($urandom_range(3) == 0) begin
        iv8 = 1'b0; a8 = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    iv8 = 1'b0;
  endtask

  task automatic drv1(input int n);
    int  tries;
    logic took;
    for (int k = 0; k < n; k++) begin
      tries = 0; took = 1'b0;
      a1 = 1'($urandom); b1 = 1'($urandom);
      bi1 = 1'($urandom); iv1 = 1'b1;
      while (!took && tries < 400) begin
        @(negedge clk); took = ir1;
        @(posedge clk); #1;
        tries++;
      end
      if (!took) begin
        chk("acc1_timeout", 64'(0), 64'(1));
        iv1 = 1'b0;
        return;
      end
      if ($urandom_range(3) == 0) begin
        iv1 = 1'b0;
        @(posedge clk); #1;
      end
    end
    iv1 = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    iv8 = 0; a8 = 0; b8 = 0; bi8 = 0; or8 = 0;
    iv1 = 0; a1 = 0; b1 = 0; bi1 = 0; or1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inr", 64'(ir8), 64'(1));
    chk("rst_ov", 64'(ov8), 64'(0));
    chk("rst_busy", 64'(busy8), 64'(0));
    chk("rst_diff", 64'(d8), 64'(0));
    chk("rst_brw", 64'(bo8), 64'(0));
    chk("rst_ovf", 64'(ovf8), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0);
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 0);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    op8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 5);

    // Reset in the middle of RUN.
    iv8 = 1'b1; a8 = 8'h33; b8 = 8'h11; bi8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy8), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("mrst_inr", 64'(ir8), 64'(1));
    chk("mrst_ov", 64'(ov8), 64'(0));
    chk("mrst_busy", 64'(busy8), 64'(0));
    chk("mrst_diff", 64'(d8), 64'(0));
    chk("mrst_brw", 64'(bo8), 64'(0));
    chk("mrst_ovf", 64'(ovf8), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0);

    // Random back-to-back traffic on both widths.
    fork
      begin
        fork
          drv8(1000);
          drv1(1000);
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          or8 = 1'($urandom);
          or1 = 1'($urandom);
        end
      end
    join
    or8 = 1'b1;
    or1 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (q8.size() == 0 && q1.size() == 0 && !busy8 && !busy1) break;
    end
    chk("drain8", 64'(q8.size()), 64'(0));
    chk("drain1", 64'(q1.size()), 64'(0));
    chk("idle8", 64'(busy8), 64'(0));
    chk("idle1", 64'(busy1), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
